serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first.
- Datapath is a full subtractor built from two half_subtractor instances plus an OR of their borrows, using the team's gate-level primitive cells.
- Counterpart to the combinational half-adder cell.
- Used where area matters more than latency; start/busy/done handshake to the host block.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk         input   1      single clock, rising-edge.
- rst         input   1      synchronous, active-high reset.
- start       input   1      request; sampled only in IDLE.
- a           input   WIDTH  minuend; captured when start is accepted.
- b           input   WIDTH  subtrahend; captured when start is accepted.
- busy        output  1      high in SHIFT state.
- done        output  1      one-cycle pulse, high in DONE state.
- diff        output  WIDTH  result register, (a - b) mod 2^WIDTH.
- borrow_out  output  1      final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset and clock: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state = IDLE; busy = 0; done = 0; diff = 0; borrow_out = 0; shift registers, borrow flop and bit counter = 0.
- rst has priority over all other inputs at every edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge E0 latches a into sa and b into sb.
  - Borrow flop is cleared, counter is set to 0, and the FSM moves to SHIFT.
  - start = 0 keeps the FSM in IDLE.
- SHIFT: each edge E1..EWIDTH does one bit step:
  - d = sa[0] ^ sb[0] ^ bor.
  - bor_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor).
  - d shifts into the result shift register from the MSB end; sa and sb shift right.
  - Counter increments.
- SHIFT exit at EWIDTH (counter == WIDTH-1):
  - diff <= completed result and borrow_out <= bor_next, both updated at the same edge.
  - FSM moves to DONE.
- DONE: done = 1 for exactly one cycle; at E(WIDTH+1) the FSM returns to IDLE unconditionally.
- Latency: done is high in the cycle following edge EWIDTH. Start-sampling edge to done edge is WIDTH+1 clocks; minimum issue interval is WIDTH+2 clocks.
- busy = 1 exactly in SHIFT (WIDTH cycles); done and busy are never both high.
- start is ignored (no queuing) in SHIFT and in DONE.
- a and b are don't-care after E0; changing them mid-operation must not affect the result.
- diff and borrow_out hold their last value until the next completion. They are not cleared when a new operation starts.
- Reset mid-operation: the FSM returns to IDLE, no done pulse is issued, and diff/borrow_out return to 0.
- Counter width is clog2(WIDTH+1). WIDTH = 1 gives a single SHIFT cycle.
- Arithmetic: modulo 2^WIDTH. borrow_out is the borrow out of the MSB with borrow-in 0.

Decomposition:
- Shared package / include: FSM state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2; default WIDTH constant.
- Sub-module half_subtractor (x, y -> d = x ^ y, bo = ~x & y), built from the existing gate cells.
- Two half_subtractor instances plus an OR gate form the per-bit full subtractor inside serial_subtractor.

Test Plan:
- WIDTH=8; a=100, b=37, pulse start:
  - busy high for 8 cycles, then done for 1 cycle.
  - diff=63, borrow_out=0; done seen 9 clocks after the start-sampling edge.
- a=5, b=10 -> diff=251 (8'hFB), borrow_out=1. Also a=0, b=1 -> diff=255, borrow_out=1. Also a=0, b=0 -> diff=0, borrow_out=0.
- a=200, b=55 accepted; 3 cycles later drive start=1 with a=1, b=1, and change a/b every cycle -> single done pulse, diff=145, borrow_out=0, no second operation.
- Start a=9, b=3; assert rst for 1 cycle at the 4th SHIFT cycle:
  - Next cycle: busy=0, done=0, diff=0, borrow_out=0, state IDLE.
  - No done pulse in the following 12 clocks.
- Back-to-back: start held high continuously with a=8'hFF, b=8'h01:
  - done every 10 clocks, diff=8'hFE, borrow_out=0 each time.
  - diff holds 8'hFE during the intervening busy cycles.
- WIDTH=1 instance, all 4 input pairs:
  - (1,0) -> diff=1, bo=0; (0,1) -> diff=1, bo=1; (1,1) and (0,0) -> diff=0, bo=0.
  - done 2 clocks after start is sampled.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor cell: difference x ^ y, borrow out when y exceeds x.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, one bit per clock, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_reg;
    logic             bor_reg;
    logic             bor_next;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic             last_bit;

    logic hs0_d, hs0_bo, bit_d, hs1_bo;

    // Full subtractor: first stage subtracts the operand bits, second stage the running borrow.
    half_subtractor u_hs0 (
        .x  (sa_reg[0]),
        .y  (sb_reg[0]),
        .d  (hs0_d),
        .bo (hs0_bo)
    );

    half_subtractor u_hs1 (
        .x  (hs0_d),
        .y  (bor_reg),
        .d  (bit_d),
        .bo (hs1_bo)
    );

    assign bor_next = hs0_bo | hs1_bo;
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH steps the first bit has reached bit 0.
    assign res_next = WIDTH'({bit_d, res_reg} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_SHIFT);
        done = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            bor_reg    <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sa_reg  <= a;
                        sb_reg  <= b;
                        bor_reg <= 1'b0;
                        cnt_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    res_reg <= res_next;
                    bor_reg <= bor_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        diff_reg   <= res_next;
                        borrow_reg <= bor_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

endmodule : serial_subtractor
